oc8051_xdata_ctrl: RTL

External data memory (MOVX) access controller, directly downstream of the DPTR register. It consumes dptr_hi/dptr_lo, or P2 with R0/R1, for MOVX addressing. It runs one strobe/acknowledge bus cycle per MOVX instruction and stalls the core until that cycle completes. For reads it returns the read byte to the ALU source path.

---
 rtl/oc8051_xdata_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/oc8051_xdata_ctrl.sv
// oc8051_xdata_ctrl: MOVX external data memory access controller.
// Runs one strobe/acknowledge bus cycle per MOVX instruction. It takes the
// address from DPTR or from {P2,Ri} and stalls the core until the cycle completes.
// Build option: define OC8051_XDATA_TIMEOUT_EN to abort accesses that wait
// TIMEOUT cycles for xdata_ack. Aborted reads return 8'hFF and pulse xdata_err.
module oc8051_xdata_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        movx_rd,
    input  logic        movx_wr,
    input  logic        addr_sel,
    input  logic [7:0]  dptr_hi,
    input  logic [7:0]  dptr_lo,
    input  logic [7:0]  p2,
    input  logic [7:0]  ri,
    input  logic [7:0]  wr_data,
    output logic [15:0] xdata_addr,
    output logic [7:0]  xdata_dat_o,
    input  logic [7:0]  xdata_dat_i,
    output logic        xdata_we,
    output logic        xdata_stb,
    input  logic        xdata_ack,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        stall,
    output logic        xdata_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The abort window is held in an 8-bit counter, so TIMEOUT must fit in 1..255.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("oc8051_xdata_ctrl: TIMEOUT must be in 1..255");
    end

    logic [1:0]  state_q, state_d;
    logic [15:0] xdata_addr_q, xdata_addr_d;
    logic [7:0]  xdata_dat_o_q, xdata_dat_o_d;
    logic        xdata_we_q, xdata_we_d;
    logic        xdata_stb_q, xdata_stb_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

`ifdef OC8051_XDATA_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [7:0]  cnt_q, cnt_d;
    logic        xdata_err_q, xdata_err_d;
`endif

    // Next-state logic: accept in IDLE, wait for ack (or abort) in REQ, then one DONE cycle
    always_comb begin
        state_d       = state_q;
        xdata_addr_d  = xdata_addr_q;
        xdata_dat_o_d = xdata_dat_o_q;
        xdata_we_d    = xdata_we_q;
        xdata_stb_d   = xdata_stb_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
`ifdef OC8051_XDATA_TIMEOUT_EN
        cnt_d         = cnt_q;
        xdata_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (movx_rd || movx_wr) begin
                    xdata_addr_d  = addr_sel ? {dptr_hi, dptr_lo} : {p2, ri};
                    xdata_dat_o_d = wr_data;
                    xdata_we_d    = movx_wr;
                    xdata_stb_d   = 1'b1;
`ifdef OC8051_XDATA_TIMEOUT_EN
                    cnt_d         = 8'd0;
`endif
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (xdata_ack) begin
                    if (!xdata_we_q) begin
                        rd_data_d  = xdata_dat_i;
                        rd_valid_d = 1'b1;
                    end
                    xdata_stb_d = 1'b0;
                    xdata_we_d  = 1'b0;
                    state_d     = DONE;
                end
`ifdef OC8051_XDATA_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    if (!xdata_we_q) begin
                        rd_data_d  = 8'hFF;
                        rd_valid_d = 1'b1;
                    end
                    xdata_stb_d = 1'b0;
                    xdata_we_d  = 1'b0;
                    xdata_err_d = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bus registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            xdata_addr_q  <= 16'h0000;
            xdata_dat_o_q <= 8'h00;
            xdata_we_q    <= 1'b0;
            xdata_stb_q   <= 1'b0;
            rd_data_q     <= 8'h00;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            xdata_addr_q  <= xdata_addr_d;
            xdata_dat_o_q <= xdata_dat_o_d;
            xdata_we_q    <= xdata_we_d;
            xdata_stb_q   <= xdata_stb_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

`ifdef OC8051_XDATA_TIMEOUT_EN
    // Wait counter and abort flag for the timeout option
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 8'd0;
            xdata_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            xdata_err_q <= xdata_err_d;
        end
    end

    assign xdata_err = xdata_err_q;
`else
    assign xdata_err = 1'b0;
`endif

    assign xdata_addr  = xdata_addr_q;
    assign xdata_dat_o = xdata_dat_o_q;
    assign xdata_we    = xdata_we_q;
    assign xdata_stb   = xdata_stb_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    // Stall the core while a request is being accepted or a bus cycle is open.
    // Reset releases the core at once.
    assign stall = !rst && (((state_q == IDLE) && (movx_rd || movx_wr)) || (state_q == REQ));

endmodule
